// File: rtl/px_osc_meter_array_pkg.sv
// Shared definitions for the pixel oscillator meter: FSM encoding, default
// parameters and a constant-function clog2 for the chip wrapper and the array.
package px_osc_meter_array_pkg;

    localparam int unsigned DEF_N_PX        = 19;
    localparam int unsigned DEF_N_GRP       = 5;
    localparam int unsigned DEF_CNT_W       = 16;
    localparam int unsigned DEF_WIN_W       = 16;
    localparam int unsigned DEF_SETTLE      = 8;
    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned SETTLE_W        = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAKE = 3'd1,
        ST_MEAS = 3'd2,
        ST_STOP = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((r < 32) && ((64'd1 << r) < 64'(v))) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/px_edge_counter.sv
// One pixel: synchroniser, rising-edge detector and saturating edge counter.
module px_edge_counter #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_px,
    input  logic             clear,
    input  logic             count_en,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    logic                   edge_c;

    assign edge_c = sync_q[SYNC_STAGES-1] & ~prev_q;

    // Synchroniser chain plus previous-sample register for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], clk_px};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Saturating count: an edge arriving at all-ones is dropped and flagged.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clear) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (count_en && edge_c) begin
            if (&cnt_q) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Counter state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign count = cnt_q;
    assign ovf   = ovf_q;

endmodule

// File: rtl/px_osc_meter_array.sv
// Pixel ring-oscillator meter: gates oscillator groups, counts synchronised
// pixel edges over a programmable window and exposes a registered read port.
module px_osc_meter_array
    import px_osc_meter_array_pkg::*;
#(
    parameter int unsigned N_PX        = DEF_N_PX,
    parameter int unsigned N_GRP       = DEF_N_GRP,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned WIN_W       = DEF_WIN_W,
    parameter int unsigned SETTLE      = DEF_SETTLE,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    localparam int unsigned AW         = (clog2(N_PX) == 0) ? 1 : clog2(N_PX)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_PX-1:0]  clk_px,
    output logic [N_GRP-1:0] stop_osc,
    input  logic             start,
    input  logic [N_GRP-1:0] grp_en,
    input  logic [WIN_W-1:0] win_len,
    output logic             busy,
    output logic             done,
    input  logic [AW-1:0]    rd_addr,
    output logic [CNT_W-1:0] rd_data,
    output logic             rd_ovf
);

    state_e                state_q, state_d;
    logic [N_GRP-1:0]      grp_en_q, grp_en_d;
    logic [WIN_W-1:0]      win_len_q, win_len_d;
    logic [WIN_W-1:0]      win_cnt_q, win_cnt_d;
    logic [SETTLE_W-1:0]   settle_q, settle_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [N_GRP-1:0]      stop_osc_q, stop_osc_d;
    logic [CNT_W-1:0]      rd_data_q, rd_data_d;
    logic                  rd_ovf_q, rd_ovf_d;
    logic                  clear_c;
    logic                  meas_c;
    logic [CNT_W-1:0]      cnt_c [N_PX];
    logic [N_PX-1:0]       ovf_c;

    assign meas_c = (state_q == ST_MEAS);

    // Measurement sequencer plus next values of the registered outputs.
    always_comb begin
        state_d   = state_q;
        grp_en_d  = grp_en_q;
        win_len_d = win_len_q;
        win_cnt_d = win_cnt_q;
        settle_d  = settle_q;
        clear_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    grp_en_d  = grp_en;
                    win_len_d = win_len;
                    settle_d  = '0;
                    clear_c   = 1'b1;
                    state_d   = ST_WAKE;
                end
            end
            ST_WAKE: begin
                if (settle_q == SETTLE_W'(SETTLE - 1)) begin
                    win_cnt_d = '0;
                    state_d   = (win_len_q == '0) ? ST_STOP : ST_MEAS;
                end else begin
                    settle_d = settle_q + SETTLE_W'(1);
                end
            end
            ST_MEAS: begin
                if (win_cnt_q == (win_len_q - WIN_W'(1))) begin
                    state_d = ST_STOP;
                end else begin
                    win_cnt_d = win_cnt_q + WIN_W'(1);
                end
            end
            ST_STOP: state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        busy_d     = (state_d == ST_WAKE) || (state_d == ST_MEAS) || (state_d == ST_STOP);
        done_d     = (state_d == ST_DONE);
        stop_osc_d = ((state_d == ST_WAKE) || (state_d == ST_MEAS)) ? ~grp_en_d : '1;
    end

    // Sequencer and control-output registers; reset parks all oscillators.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            grp_en_q   <= '0;
            win_len_q  <= '0;
            win_cnt_q  <= '0;
            settle_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            stop_osc_q <= '1;
        end else begin
            state_q    <= state_d;
            grp_en_q   <= grp_en_d;
            win_len_q  <= win_len_d;
            win_cnt_q  <= win_cnt_d;
            settle_q   <= settle_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            stop_osc_q <= stop_osc_d;
        end
    end

    // Per-pixel counters; pixel i is gated by group i mod N_GRP.
    for (genvar i = 0; i < N_PX; i++) begin : g_px
        px_edge_counter #(
            .CNT_W      (CNT_W),
            .SYNC_STAGES(SYNC_STAGES)
        ) u_cnt (
            .clk     (clk),
            .rst     (rst),
            .clk_px  (clk_px[i]),
            .clear   (clear_c),
            .count_en(meas_c & grp_en_q[i % N_GRP]),
            .count   (cnt_c[i]),
            .ovf     (ovf_c[i])
        );
    end

    // Read mux; out-of-range addresses return zero.
    always_comb begin
        rd_data_d = '0;
        rd_ovf_d  = 1'b0;
        for (int unsigned i = 0; i < N_PX; i++) begin
            if (rd_addr == AW'(i)) begin
                rd_data_d = cnt_c[i];
                rd_ovf_d  = ovf_c[i];
            end
        end
    end

    // Registered read port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
            rd_ovf_q  <= 1'b0;
        end else begin
            rd_data_q <= rd_data_d;
            rd_ovf_q  <= rd_ovf_d;
        end
    end

    assign stop_osc = stop_osc_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign rd_data  = rd_data_q;
    assign rd_ovf   = rd_ovf_q;

endmodule

// File: tb/tb_px_osc_meter_array.sv
// Scoreboard bench: stimulus pushes expected measurement results, a monitor
// pops one on every done pulse and sweeps the read port against it.
module tb_px_osc_meter_array;

    localparam int unsigned N_PX   = 19;
    localparam int unsigned N_GRP  = 5;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned WIN_W  = 16;
    localparam int unsigned SETTLE = 8;
    localparam int unsigned AW     = 5;
    localparam int          BIG    = 32'h3fff_ffff;

    typedef struct {
        int unsigned             done_cyc;
        logic [N_PX-1:0][15:0]   lo;
        logic [N_PX-1:0][15:0]   hi;
        logic [N_PX-1:0]         ovf;
    } exp_t;

    logic             clk;
    logic             rst;
    logic [N_PX-1:0]  clk_px;
    logic [N_GRP-1:0] stop_osc;
    logic             start;
    logic [N_GRP-1:0] grp_en;
    logic [WIN_W-1:0] win_len;
    logic             busy;
    logic             done;
    logic [AW-1:0]    rd_addr;
    logic [CNT_W-1:0] rd_data;
    logic             rd_ovf;

    int          n_chk;
    int          n_pass;
    int unsigned cyc;
    int          sweeps;
    int          per [N_PX];
    int          lim [N_PX];
    int          epoch;
    exp_t        sb_q [$];

    px_osc_meter_array #(
        .N_PX(N_PX), .N_GRP(N_GRP), .CNT_W(CNT_W), .WIN_W(WIN_W),
        .SETTLE(SETTLE), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .rst(rst), .clk_px(clk_px), .stop_osc(stop_osc),
        .start(start), .grp_en(grp_en), .win_len(win_len), .busy(busy),
        .done(done), .rd_addr(rd_addr), .rd_data(rd_data), .rd_ovf(rd_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    task automatic chk(input string nm, input longint act, input longint lo, input longint hi);
        n_chk = n_chk + 1;
        if (act >= lo && act <= hi) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0d, want %0d..%0d", nm, act, lo, hi);
    endtask

    // Pixel clock generator: period per[i] clk cycles, at most lim[i] rising edges per epoch.
    initial begin
        int ph [N_PX];
        int em [N_PX];
        int last;
        last   = -1;
        clk_px = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N_PX; i++) begin
                if (epoch != last) begin
                    ph[i] = 0;
                    em[i] = 0;
                    clk_px[i] = 1'b0;
                end
                if (per[i] == 0) begin
                    ph[i] = 0;
                    clk_px[i] = 1'b0;
                end else begin
                    ph[i] = (ph[i] + 1) % per[i];
                    if (ph[i] == 0) begin
                        if (em[i] < lim[i]) begin
                            clk_px[i] = 1'b1;
                            em[i] = em[i] + 1;
                        end
                    end else if (ph[i] == per[i] / 2) begin
                        clk_px[i] = 1'b0;
                    end
                end
            end
            last = epoch;
        end
    end

    // Monitor: on each done pulse pop an expectation and sweep the read port.
    initial begin
        exp_t e;
        sweeps  = 0;
        rd_addr = '0;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                chk("done_expected", sb_q.size(), 1, BIG);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    chk("done_cycle", cyc, e.done_cyc, e.done_cyc);
                    chk("busy_at_done", busy, 0, 0);
                    for (int a = 0; a <= N_PX; a++) begin
                        rd_addr = AW'(a);
                        @(negedge clk);
                        if (a == 0) chk("done_width", done, 0, 0);
                        if (a < N_PX) begin
                            chk($sformatf("px%0d_count", a), rd_data, e.lo[a], e.hi[a]);
                            chk($sformatf("px%0d_ovf", a), rd_ovf, e.ovf[a], e.ovf[a]);
                        end else begin
                            chk("oob_data", rd_data, 0, 0);
                            chk("oob_ovf", rd_ovf, 0, 0);
                        end
                    end
                    sweeps = sweeps + 1;
                end
            end
        end
    end

    task automatic launch(input logic [N_GRP-1:0] g, input int w, output int unsigned c);
        grp_en  = g;
        win_len = WIN_W'(w);
        start   = 1'b1;
        c       = cyc;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic wait_until(input int unsigned t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_sweep(input int s0, input int budget);
        int k;
        k = 0;
        while (sweeps == s0 && k < budget) begin
            @(negedge clk);
            k = k + 1;
        end
        chk("sweep_complete", sweeps, s0 + 1, s0 + 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    // Directed stimulus.
    initial begin
        exp_t        e;
        int unsigned c;
        int          s0;
        n_chk   = 0;
        n_pass  = 0;
        rst     = 1'b1;
        start   = 1'b0;
        grp_en  = '0;
        win_len = '0;
        for (int i = 0; i < N_PX; i++) begin
            per[i] = 4 + i;
            lim[i] = BIG;
        end
        epoch = 1;

        // Reset with pixels toggling.
        repeat (3) @(negedge clk);
        chk("rst_stop_osc", stop_osc, 5'h1f, 5'h1f);
        chk("rst_busy", busy, 0, 0);
        chk("rst_done", done, 0, 0);
        chk("rst_rd_data", rd_data, 0, 0);
        chk("rst_rd_ovf", rd_ovf, 0, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_stop_osc", stop_osc, 5'h1f, 5'h1f);

        // Zero-length window: no counting at all.
        s0 = sweeps;
        launch(5'h1f, 0, c);
        chk("w0_busy", busy, 1, 1);
        chk("w0_stop_osc_wake", stop_osc, 0, 0);
        e.done_cyc = c + SETTLE + 2;
        e.lo = '0; e.hi = '0; e.ovf = '0;
        sb_q.push_back(e);
        wait_sweep(s0, 200);

        // All groups, window 1000, with starts during MEAS and in the DONE cycle.
        s0 = sweeps;
        launch(5'h1f, 1000, c);
        e.done_cyc = c + SETTLE + 1000 + 2;
        for (int i = 0; i < N_PX; i++) begin
            e.lo[i] = 16'(1000 / (4 + i));
            e.hi[i] = 16'((1000 + 3 + i) / (4 + i));
        end
        e.ovf = '0;
        sb_q.push_back(e);
        wait_until(c + 100);
        grp_en  = 5'h00;
        win_len = 16'd5;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        wait_until(e.done_cyc);
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        chk("done_cycle_start_ignored", busy, 0, 0);
        chk("after_done_stop_osc", stop_osc, 5'h1f, 5'h1f);
        wait_sweep(s0, 1200);

        // Partial group enable.
        s0 = sweeps;
        launch(5'b00101, 300, c);
        chk("grp_stop_osc_wake", stop_osc, 5'b11010, 5'b11010);
        wait_until(c + 50);
        chk("grp_stop_osc_meas", stop_osc, 5'b11010, 5'b11010);
        chk("grp_busy_meas", busy, 1, 1);
        e.done_cyc = c + SETTLE + 300 + 2;
        for (int i = 0; i < N_PX; i++) begin
            if ((i % 5 == 0) || (i % 5 == 2)) begin
                e.lo[i] = 16'(300 / (4 + i));
                e.hi[i] = 16'((300 + 3 + i) / (4 + i));
            end else begin
                e.lo[i] = '0;
                e.hi[i] = '0;
            end
        end
        e.ovf = '0;
        sb_q.push_back(e);
        wait_sweep(s0, 500);

        // Saturation on pixel 0, exactly 10 edges on pixel 1.
        for (int i = 0; i < N_PX; i++) begin
            per[i] = 0;
            lim[i] = BIG;
        end
        per[0] = 4;
        epoch  = epoch + 1;
        s0 = sweeps;
        launch(5'h1f, 1100, c);
        e.done_cyc = c + SETTLE + 1100 + 2;
        e.lo = '0; e.hi = '0; e.ovf = '0;
        e.lo[0] = 16'd255; e.hi[0] = 16'd255; e.ovf[0] = 1'b1;
        e.lo[1] = 16'd10;  e.hi[1] = 16'd10;
        sb_q.push_back(e);
        wait_until(c + 40);
        per[1] = 6;
        lim[1] = 10;
        epoch  = epoch + 1;
        wait_sweep(s0, 1300);

        // Reset in the middle of MEAS aborts and parks all oscillators.
        for (int i = 0; i < N_PX; i++) begin
            per[i] = 4 + i;
            lim[i] = BIG;
        end
        epoch = epoch + 1;
        launch(5'b00011, 1000, c);
        wait_until(c + 60);
        chk("pre_rst_stop_osc", stop_osc, 5'b11100, 5'b11100);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_stop_osc", stop_osc, 5'h1f, 5'h1f);
        chk("mid_rst_busy", busy, 0, 0);
        chk("mid_rst_rd_data", rd_data, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (1100) @(negedge clk);
        chk("post_rst_busy", busy, 0, 0);
        chk("post_rst_no_pending", sb_q.size(), 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/px_osc_meter_array.md
Name: px_osc_meter_array

Overview:
Parametrised digital front end for the pixel ring-oscillator array. It gates each oscillator group through stop_osc and counts rising edges of every pixel clock over a programmable window. Counts are held in a per-pixel result register file that the readout logic reads. It sits between the analog pixel array (sources clk_px, sinks stop_osc) and the chip readout/control logic. Unlike the fixed 19-pixel/5-group array, it has configurable pixel and group counts, per-group enables, a settle phase, saturating counters and an overflow flag.

Parameters:
N_PX, 19, number of pixel oscillator clocks
N_GRP, 5, number of stop_osc groups; pixel i belongs to group (i mod N_GRP)
CNT_W, 16, per-pixel edge counter width
WIN_W, 16, width of window length input
SETTLE, 8, clk cycles between releasing stop_osc and opening the count window (1..255)
SYNC_STAGES, 2, synchroniser flops per pixel clock (>=2)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
clk_px  input  N_PX  raw pixel oscillator outputs, asynchronous to clk
stop_osc  output  N_GRP  1 = hold group's oscillators stopped
start  input  1  single-cycle measurement request
grp_en  input  N_GRP  groups to run; sampled on accepted start
win_len  input  WIN_W  count window in clk cycles; sampled on accepted start
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse when results are valid
rd_addr  input  clog2(N_PX)  result index
rd_data  output  CNT_W  count for pixel rd_addr, registered
rd_ovf  output  1  saturation flag for pixel rd_addr, registered

Behaviour:
- Reset (async, any state): FSM=IDLE; stop_osc=all 1; busy=0; done=0; all counts, ovf flags, rd_data and rd_ovf = 0; synchronisers cleared.
- Each clk_px bit passes through SYNC_STAGES flops, then a rising-edge detector (previous-sample register). Pixel frequency must stay below clk/2. Faster inputs alias; this is not detected.
- FSM states:
  - IDLE: start=1 latches grp_en and win_len, clears all counts and ovf flags, sets busy, and goes to WAKE.
  - WAKE: stop_osc[g] = ~grp_en_q[g]. A settle counter runs SETTLE cycles, then the FSM goes to MEAS. If win_len_q=0, it goes directly to STOP and counts stay 0.
  - MEAS: window counter runs win_len_q cycles. Each detected edge of an enabled-group pixel increments that pixel's count. At all-ones the count holds and ovf is set. Disabled-group pixels never count.
  - STOP: stop_osc=all 1. Counting is frozen. One cycle later the FSM goes to DONE.
  - DONE: done=1 for exactly one cycle, busy=0, FSM returns to IDLE.
- Counting window is exactly win_len_q clk cycles: first counted sample is the first MEAS cycle, last is the cycle before STOP. Edges still in the synchroniser when the window closes are discarded.
- start while busy is ignored; no queueing. start in the DONE cycle is also ignored.
- Results hold from done until the next accepted start.
- Readout is available in any state, with 1-cycle latency: rd_data/rd_ovf reflect rd_addr from the previous cycle. rd_addr >= N_PX returns 0/0. During a measurement, reads return live partial counts.
- Reset mid-measurement aborts immediately and stops all oscillators (stop_osc=1 asynchronously with rst).
- Counter arithmetic is unsigned, CNT_W bits, saturating and never wrapping. Window and settle counters are sized to WIN_W and 8 bits.

Decomposition:
- Shared package/include holds: FSM state encoding (IDLE, WAKE, MEAS, STOP, DONE), the clog2 helper, and the default parameter constants, for reuse by the top-level chip wrapper.
- Natural sub-module: px_edge_counter, one instance per pixel. It contains the synchroniser, edge detector, saturating CNT_W counter and ovf flag, with inputs clear, count_en and clk_px, and outputs count and ovf.
- FSM, group-to-pixel enable mapping and read mux stay in the top module.

Test Plan:
- Reset with clk_px toggling -> stop_osc=5'b11111, busy=0, all reads return 0; assert rst mid-MEAS -> same values within the rst edge.
- All groups enabled, pixel i toggling with period (4+i) clk, win_len=1000, SETTLE=8 -> done 8+1000+2 cycles after start; rd_data[i] = floor or ceil of 1000/(4+i).
- grp_en=5'b00101 -> stop_osc=5'b11010 during WAKE/MEAS; only pixels with i mod 5 in {0,2} have nonzero counts; others read 0.
- CNT_W=4, pixel toggling every 2 clk, win_len=100 -> rd_data=15, rd_ovf=1; a pixel producing 10 edges -> 10, ovf=0.
- win_len=0 -> done asserts after WAKE+STOP+DONE, all counts 0, no counting observed.
- start pulsed again while busy and in the DONE cycle -> ignored, single done pulse; rd_addr=19 -> rd_data=0; rd_addr change reflected on rd_data one cycle later.
